// File: rtl/secure_alu_pkg.sv
// rtl/secure_alu_pkg.sv - shared constants, mode/state encodings and decrypt helper for the secure ALU result path
package secure_alu_pkg;

  localparam logic [7:0] KEY_DEFAULT      = 8'hA5;
  localparam logic [3:0] NIB_MASK_DEFAULT = 4'hC;

  localparam logic MODE_XOR = 1'b0;
  localparam logic MODE_NIB = 1'b1;

  // Key FSM encoding, also used by the matching encryptor
  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_REKEY = 1'b1
  } key_state_e;

  // One FIFO word: integrity flag above the recovered byte
  typedef struct packed {
    logic       err;
    logic [7:0] data;
  } dec_word_t;

  localparam int DEC_WORD_W = $bits(dec_word_t);

  // Reverse either encryption; nibble mode requires a zero upper nibble
  function automatic dec_word_t decrypt_byte(
    input logic [7:0] din,
    input logic       mode,
    input logic [7:0] key,
    input logic [3:0] mask
  );
    dec_word_t w;
    if (mode == MODE_NIB) begin
      w.data = {4'h0, din[3:0] ^ mask};
      w.err  = |din[7:4];
    end else begin
      w.data = din ^ key;
      w.err  = 1'b0;
    end
    return w;
  endfunction

endpackage

// File: rtl/dec_fifo2.sv
// rtl/dec_fifo2.sv - two-entry synchronous FIFO holding decrypted words
module dec_fifo2 #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head_data,
  output logic [1:0]   count
);

  logic [W-1:0] mem [2];
  logic         rd_ptr;
  logic         wr_ptr;
  logic         push_en;
  logic         pop_en;

  // Never overwrite a full FIFO or pop an empty one, whatever the caller does
  assign push_en   = push && (count != 2'd2);
  assign pop_en    = pop && (count != 2'd0);
  assign head_data = mem[rd_ptr];

  // Storage, pointers and occupancy; reset flushes everything
  always_ff @(posedge clk) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push_en) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop_en) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push_en, pop_en})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/secure_alu_decryptor.sv
// rtl/secure_alu_decryptor.sv - receive-side decryptor with key update FSM, output buffer and counters
module secure_alu_decryptor
  import secure_alu_pkg::*;
#(
  parameter logic [7:0] KEY_RESET = KEY_DEFAULT,
  parameter logic [3:0] NIB_MASK  = NIB_MASK_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  input  logic        in_mode,
  input  logic        key_valid,
  output logic        key_ready,
  input  logic [7:0]  key_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic        out_err,
  output logic [15:0] byte_count,
  output logic [7:0]  err_count
);

  key_state_e state;
  key_state_e state_nxt;
  logic [7:0] key;
  logic [7:0] key_next;
  logic [1:0] fifo_count;
  logic [DEC_WORD_W-1:0] head_raw;
  dec_word_t  head;
  dec_word_t  dec_word;
  logic       in_fire;
  logic       out_fire;
  logic       key_fire;

  assign in_fire  = in_valid && in_ready;
  assign key_fire = key_valid && key_ready;
  assign out_fire = out_valid && out_ready;

  // Decrypt uses the key register as it stands, so a byte taken alongside a key handshake sees the old key
  assign dec_word = decrypt_byte(in_data, in_mode, key, NIB_MASK);

  dec_fifo2 #(
    .W(DEC_WORD_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (in_fire),
    .push_data (dec_word),
    .pop       (out_fire),
    .head_data (head_raw),
    .count     (fifo_count)
  );

  assign head      = dec_word_t'(head_raw);
  assign out_valid = (fifo_count != 2'd0);
  assign out_data  = out_valid ? head.data : 8'h00;
  assign out_err   = out_valid ? head.err  : 1'b0;

  // Key FSM state, staged key and live key; the live key only changes in REKEY
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_RUN;
      key      <= KEY_RESET;
      key_next <= KEY_RESET;
    end else begin
      state <= state_nxt;
      if (key_fire) begin
        key_next <= key_data;
      end
      if (state == ST_REKEY) begin
        key <= key_next;
      end
    end
  end

  // Next state and handshake readies, decoded from registered state only
  always_comb begin
    state_nxt = state;
    key_ready = 1'b0;
    in_ready  = 1'b0;
    case (state)
      ST_RUN: begin
        key_ready = 1'b1;
        in_ready  = (fifo_count != 2'd2);
        if (key_valid) begin
          state_nxt = ST_REKEY;
        end
      end
      ST_REKEY: begin
        state_nxt = ST_RUN;
      end
      default: begin
        state_nxt = ST_RUN;
      end
    endcase
  end

  // Accepted-byte counter wraps; error counter saturates
  always_ff @(posedge clk) begin
    if (rst) begin
      byte_count <= 16'h0000;
      err_count  <= 8'h00;
    end else if (in_fire) begin
      byte_count <= byte_count + 16'h0001;
      if (dec_word.err && (err_count != 8'hFF)) begin
        err_count <= err_count + 8'h01;
      end
    end
  end

endmodule

// File: tb/tb_secure_alu_decryptor.sv
// tb/tb_secure_alu_decryptor.sv - directed self-checking bench for secure_alu_decryptor
module tb_secure_alu_decryptor;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        in_mode;
  logic        key_valid;
  logic        key_ready;
  logic [7:0]  key_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_err;
  logic [15:0] byte_count;
  logic [7:0]  err_count;

  int errors = 0;
  int checks = 0;
  int exp_bytes = 0;
  int exp_errs = 0;

  typedef struct {
    logic       mode;
    logic [7:0] din;
    logic [7:0] exp_data;
    logic       exp_err;
  } vec_t;

  vec_t vecs[7];

  secure_alu_decryptor dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_mode    (in_mode),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .key_data   (key_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_err    (out_err),
    .byte_count (byte_count),
    .err_count  (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Hold in_valid high until n bytes are accepted, bounded by a cycle budget
  task automatic stream(input logic mode, input logic [7:0] data, input int n, output int acc);
    int cyc;
    cyc = 0;
    acc = 0;
    @(negedge clk);
    out_ready = 1'b1;
    in_mode   = mode;
    in_data   = data;
    in_valid  = 1'b1;
    while (acc < n && cyc < n + 20) begin
      if (in_ready) acc++;
      cyc++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("stream_accepts", acc, n);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    key_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    exp_bytes = 0;
    exp_errs = 0;
  endtask

  initial begin
    int acc;

    vecs[0] = '{1'b0, 8'hAD, 8'h08, 1'b0};
    vecs[1] = '{1'b1, 8'h04, 8'h08, 1'b0};
    vecs[2] = '{1'b1, 8'h14, 8'h08, 1'b1};
    vecs[3] = '{1'b0, 8'h00, 8'hA5, 1'b0};
    vecs[4] = '{1'b0, 8'hFF, 8'h5A, 1'b0};
    vecs[5] = '{1'b1, 8'h0F, 8'h03, 1'b0};
    vecs[6] = '{1'b1, 8'hF0, 8'h0C, 1'b1};

    rst = 1'b1;
    in_valid = 1'b0;
    in_data = 8'h00;
    in_mode = 1'b0;
    key_valid = 1'b0;
    key_data = 8'h00;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_err", out_err, 0);
    check("rst_byte_count", byte_count, 0);
    check("rst_err_count", err_count, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_key_ready", key_ready, 1);
    rst = 1'b0;

    // Single-byte table, one cycle latency
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      check("vec_in_ready", in_ready, 1);
      in_mode  = vecs[i].mode;
      in_data  = vecs[i].din;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      exp_bytes++;
      if (vecs[i].exp_err) exp_errs++;
      check($sformatf("vec%0d_out_valid", i), out_valid, 1);
      check($sformatf("vec%0d_out_data", i), out_data, vecs[i].exp_data);
      check($sformatf("vec%0d_out_err", i), out_err, vecs[i].exp_err);
      check($sformatf("vec%0d_byte_count", i), byte_count, exp_bytes);
      check($sformatf("vec%0d_err_count", i), err_count, exp_errs);
    end

    // Backpressure: FIFO fills at two, drains in order
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_ready0", in_ready, 1);
    in_mode = 1'b0;
    in_data = 8'hA5;
    in_valid = 1'b1;
    @(negedge clk);
    check("bp_ready1", in_ready, 1);
    check("bp_first_out", out_data, 8'h00);
    in_data = 8'hA4;
    @(negedge clk);
    check("bp_full_ready", in_ready, 0);
    in_data = 8'hA7;
    @(negedge clk);
    check("bp_still_full", in_ready, 0);
    check("bp_hold_data", out_data, 8'h00);
    check("bp_hold_valid", out_valid, 1);
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_drain1", out_data, 8'h01);
    check("bp_ready_after_pop", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_drain2", out_data, 8'h02);
    check("bp_drain2_valid", out_valid, 1);
    @(negedge clk);
    check("bp_empty", out_valid, 0);
    exp_bytes += 3;
    check("bp_byte_count", byte_count, exp_bytes);

    // Rekey while streaming
    @(negedge clk);
    check("rk_key_ready", key_ready, 1);
    check("rk_in_ready", in_ready, 1);
    in_mode = 1'b0;
    in_data = 8'hA5;
    in_valid = 1'b1;
    key_data = 8'h3C;
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    check("rk_in_ready_low", in_ready, 0);
    check("rk_key_ready_low", key_ready, 0);
    check("rk_old_key_data", out_data, 8'h00);
    in_data = 8'h3D;
    @(negedge clk);
    check("rk_in_ready_back", in_ready, 1);
    check("rk_gap_empty", out_valid, 0);
    @(negedge clk);
    in_valid = 1'b0;
    check("rk_new_key_data", out_data, 8'h01);
    check("rk_new_key_valid", out_valid, 1);
    exp_bytes += 2;
    check("rk_byte_count", byte_count, exp_bytes);

    // Counter wrap and saturation
    do_reset();
    stream(1'b0, 8'h00, 65537, acc);
    @(negedge clk);
    check("cnt_wrap", byte_count, 16'h0001);
    check("cnt_wrap_err", err_count, 0);
    stream(1'b1, 8'h10, 300, acc);
    @(negedge clk);
    check("cnt_err_sat", err_count, 8'hFF);
    check("cnt_bytes_after", byte_count, 16'd301);

    // Reset with two bytes buffered and a rekey pending
    @(negedge clk);
    out_ready = 1'b0;
    in_mode = 1'b0;
    in_data = 8'h11;
    in_valid = 1'b1;
    @(negedge clk);
    in_data = 8'h22;
    key_data = 8'h3C;
    key_valid = 1'b1;
    @(negedge clk);
    check("rr_full", out_valid, 1);
    check("rr_rekey", key_ready, 0);
    in_valid = 1'b0;
    key_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rr_out_valid", out_valid, 0);
    check("rr_byte_count", byte_count, 0);
    check("rr_err_count", err_count, 0);
    check("rr_in_ready", in_ready, 1);
    out_ready = 1'b1;
    in_data = 8'hA5;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("rr_key_restored", out_data, 8'h00);
    check("rr_bytes_one", byte_count, 1);
    @(negedge clk);
    check("rr_final_empty", out_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
